// File: rtl/ser_par_capture_if.sv
// ser_par_capture_if: serial-in / parallel-out bus for ser_par_capture.
// The master drives the serial bit stream and controls. The slave is the
// capture stage, which returns the assembled word and status.
interface ser_par_capture_if #(
    parameter int WIDTH = 8
);
    logic             D;
    logic             D_VLD;
    logic             S;
    logic             CLR;
    logic             OUT_RDY;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QBAR;
    logic             OUT_VLD;
    logic             OVR;

    modport master (
        output D, D_VLD, S, CLR, OUT_RDY,
        input  Q, QBAR, OUT_VLD, OVR
    );

    modport slave (
        input  D, D_VLD, S, CLR, OUT_RDY,
        output Q, QBAR, OUT_VLD, OVR
    );
endinterface

// File: rtl/ser_par_capture.sv
// ser_par_capture: serial-to-parallel capture stage feeding a WIDTH-bit
// set/reset flop bank. Words are presented with a valid/ready handshake.
// Streaming has no bubble: a bit that arrives in the transfer cycle starts
// the next word. The sticky OVR flag records bits that were dropped while a
// word was held. Synchronous CLR has priority over S, and S has priority
// over shifting.
// Optional build macro SER_PAR_LSB_FIRST_EN: shift right (LSB first)
// instead of the default left shift (MSB first).
module ser_par_capture #(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                R,
    ser_par_capture_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovr;
    logic             r_out_vld;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovr_nxt;
    logic [WIDTH-1:0] w_q_shift;

    // Insert the incoming bit at the end of the word selected by the build.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] q,
                                                 input logic d);
`ifdef SER_PAR_LSB_FIRST_EN
        return {d, q[WIDTH-1:1]};
`else
        return {q[WIDTH-2:0], d};
`endif
    endfunction

    assign w_q_shift = f_shift(r_q, bus.D);

    // Next-state logic. Priority is CLR, then S, then handshake and shift.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_ovr_nxt   = r_ovr;
        if (bus.CLR) begin
            w_state_nxt = FILL;
            w_q_nxt     = '0;
            w_cnt_nxt   = '0;
            w_ovr_nxt   = 1'b0;
        end else if (bus.S) begin
            w_state_nxt = FILL;
            w_q_nxt     = '1;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                FILL: begin
                    // OUT_RDY has no effect while a word is being collected.
                    if (bus.D_VLD) begin
                        w_q_nxt = w_q_shift;
                        if (r_cnt == LAST_CNT) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = HOLD;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.OUT_RDY) begin
                        // The word transfers. A bit arriving in this cycle
                        // becomes the first bit of the next word.
                        w_state_nxt = FILL;
                        if (bus.D_VLD) begin
                            w_q_nxt   = w_q_shift;
                            w_cnt_nxt = ONE_CNT;
                        end
                    end else if (bus.D_VLD) begin
                        // Nowhere to put the bit, so it is lost.
                        w_ovr_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

    // State and datapath registers. OUT_VLD is a registered decode of HOLD.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state   <= FILL;
            r_q       <= '0;
            r_cnt     <= '0;
            r_ovr     <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ovr     <= w_ovr_nxt;
            r_out_vld <= (w_state_nxt == HOLD);
        end
    end

    assign bus.Q       = r_q;
    assign bus.QBAR    = ~r_q;
    assign bus.OUT_VLD = r_out_vld;
    assign bus.OVR     = r_ovr;
endmodule
